btn_conditioner: RTL
====================

BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, giving the consecutive stable cycles required to accept a level change (10 ms at 100 MHz).
REQ-002 The block SHALL have parameter CNT_W, default 20, giving the debounce counter width; it SHALL satisfy 2^CNT_W > DEBOUNCE_CYCLES.
REQ-003 CLK  in  1  system clock, 100 MHz; the block SHALL use one clock only.
REQ-004 CPU_RESETN  in  1  reset, asynchronous, active-low.
REQ-005 BTNU, BTND, BTNL, BTNR, BTNC  in  1 each  raw, asynchronous pushbutton levels (1 = pressed).
REQ-006 press_valid  out  1  single-cycle pulse: one accepted press.
REQ-007 press_code  out  3  code of the accepted press: 0=U, 1=D, 2=L, 3=R, 4=C; valid with press_valid.
REQ-008 btn_held  out  1  high while the accepted button remains pressed; drives the game's note selection.
REQ-009 held_code  out  3  code of the held button; valid while btn_held=1.
REQ-010 multi_press  out  1  high while the lockout state is active.

Function
REQ-011 Each raw button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-012 Each synchronized button SHALL have its own debounce counter.
REQ-013 The counter SHALL clear whenever the synchronized level equals the debounced level.
REQ-014 The counter SHALL increment while the two levels differ.
REQ-015 When the counter reaches DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level SHALL take the synchronized value on the next edge and the counter SHALL clear.
REQ-016 A glitch shorter than DEBOUNCE_CYCLES cycles SHALL leave the debounced level unchanged.
REQ-017 The FSM SHALL have three states: IDLE, HELD and LOCKOUT.
REQ-018 IDLE, exactly one debounced button high: go to HELD, pulse press_valid for one cycle with press_code, and load held_code.
REQ-019 IDLE, two or more debounced buttons rising on the same edge: go to LOCKOUT with no press_valid.
REQ-020 HELD: btn_held=1.
REQ-021 HELD, held button debounced low and no other button high: go to IDLE.
REQ-022 HELD, any other debounced button high: go to LOCKOUT; btn_held drops on the same edge; no press_valid.
REQ-023 LOCKOUT: multi_press=1; leave to IDLE only when all debounced buttons are low.
REQ-024 Holding a button SHALL produce exactly one press_valid; a new press requires a return to IDLE.
REQ-025 Latency: a clean raw press first sampled at edge k SHALL give press_valid high in the cycle after edge k+DEBOUNCE_CYCLES+2.
REQ-026 Release latency SHALL equal press latency: btn_held falls DEBOUNCE_CYCLES+3 edges after the raw release is first sampled.
REQ-027 press_valid, btn_held and multi_press SHALL be registered outputs (no combinational path from inputs).
REQ-028 The counters SHALL saturate and never wrap: the clear in REQ-015 bounds them at DEBOUNCE_CYCLES-1.

Reset
REQ-029 CPU_RESETN low SHALL asynchronously clear all synchronizer flops, debounced levels and counters, and set the FSM to IDLE.
REQ-030 Output values during reset SHALL be: press_valid=0, press_code=0, btn_held=0, held_code=0, multi_press=0.
REQ-031 A button held through reset release SHALL be debounced as a new press, giving one press_valid after the REQ-025 latency.
REQ-032 Reset asserted mid-debounce or mid-HELD SHALL abort the operation with no pulse emitted.

Structure
REQ-033 The button codes (BTN_U..BTN_C), the FSM state encoding and DEBOUNCE_CYCLES_DEFAULT SHALL live in shared package simon_pkg, also used by game.
REQ-034 The synchronizer and debounce logic SHALL be one sub-module, debounce, instantiated five times.
REQ-035 The FSM and the code encoder SHALL live in btn_conditioner.

Verification (DEBOUNCE_CYCLES=4, CNT_W=3)
REQ-036 Clean press: BTNL high at edge 10, held 20 cycles -> press_valid=1 for one cycle after edge 16 with press_code=2; btn_held=1 and held_code=2 until 7 edges after release.
REQ-037 Bounce: BTNR toggles with 3-cycle pulses for 12 cycles, then stays high -> exactly one press_valid, code=3, after the 4-cycle stable window.
REQ-038 Simultaneous press: BTNU and BTNC rise on the same edge -> no press_valid; multi_press=1 until both are released and debounced; then IDLE.
REQ-039 Second button while held: BTND held, then BTNC added -> btn_held drops and multi_press=1; releasing only BTNC keeps LOCKOUT; releasing both -> IDLE; no second press_valid.
REQ-040 Reset mid-hold: CPU_RESETN pulsed low during HELD -> all outputs 0 immediately; button still held after reset -> one press_valid after 7 edges.
REQ-041 Repeat press: BTNC pressed, released, pressed again with 10-cycle gaps -> two press_valid pulses, each with code=4.

Source files
------------

// File: rtl/simon_pkg.sv
// simon_pkg
// Definitions shared by the button conditioner and the game logic.
//   DEBOUNCE_CYCLES_DEFAULT : stable cycles needed to accept a level change
//                             (10 ms at 100 MHz)
//   NUM_BTNS                : number of pushbuttons on the board
//   BTN_U..BTN_C            : 3-bit button codes carried on press_code/held_code
//   btn_state_e             : conditioner FSM states
//   countPressed()          : number of set bits in a button level vector
package simon_pkg;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;
    localparam int NUM_BTNS                = 5;

    localparam logic [2:0] BTN_U = 3'd0;
    localparam logic [2:0] BTN_D = 3'd1;
    localparam logic [2:0] BTN_L = 3'd2;
    localparam logic [2:0] BTN_R = 3'd3;
    localparam logic [2:0] BTN_C = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HELD    = 2'd1,
        ST_LOCKOUT = 2'd2
    } btn_state_e;

    // Bit i of the vector is the button whose code is i.
    function automatic logic [2:0] countPressed(input logic [NUM_BTNS-1:0] levels);
        logic [2:0] total;
        total = '0;
        for (int i = 0; i < NUM_BTNS; i++) begin
            total = total + {2'b00, levels[i]};
        end
        return total;
    endfunction

endpackage

// File: rtl/debounce.sv
// debounce
// Two-flop synchronizer followed by a saturating stability counter for one
// raw pushbutton. The debounced level only follows the synchronized level
// once the two have differed for DEBOUNCE_CYCLES consecutive cycles.
//   clk_i   : system clock
//   rst_ni  : asynchronous active-low reset
//   btn_i   : raw asynchronous button level (1 = pressed)
//   level_o : debounced level
// CNT_W must satisfy 2**CNT_W > DEBOUNCE_CYCLES.
module debounce
    import simon_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = 20
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic level_o
);

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             syncMeta_q;
    logic             syncStable_q;
    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // The counter only runs while the synchronized and debounced levels
    // disagree. Reaching LAST_COUNT with the disagreement still present means
    // the new level has been stable long enough, so it is adopted and the
    // counter restarts from zero; this also keeps the counter from ever
    // passing LAST_COUNT.
    always_comb begin
        level_d = level_q;
        count_d = '0;
        if (syncStable_q != level_q) begin
            if (count_q == LAST_COUNT) begin
                level_d = syncStable_q;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            syncMeta_q   <= 1'b0;
            syncStable_q <= 1'b0;
            level_q      <= 1'b0;
            count_q      <= '0;
        end else begin
            syncMeta_q   <= btn_i;
            syncStable_q <= syncMeta_q;
            level_q      <= level_d;
            count_q      <= count_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner
// Turns the five raw board pushbuttons into clean single-press events for
// the game. Each button is synchronized and debounced, then an FSM accepts
// exactly one button at a time and locks out while several are pressed.
//   CLK, CPU_RESETN           : clock, asynchronous active-low reset
//   BTNU/BTND/BTNL/BTNR/BTNC  : raw button levels (1 = pressed)
//   press_valid / press_code  : one-cycle pulse and code of an accepted press
//   btn_held / held_code      : accepted button still pressed, and its code
//   multi_press               : more than one button involved, input ignored
module btn_conditioner
    import simon_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = 20
) (
    input  logic       CLK,
    input  logic       CPU_RESETN,
    input  logic       BTNU,
    input  logic       BTND,
    input  logic       BTNL,
    input  logic       BTNR,
    input  logic       BTNC,
    output logic       press_valid,
    output logic [2:0] press_code,
    output logic       btn_held,
    output logic [2:0] held_code,
    output logic       multi_press
);

    logic [NUM_BTNS-1:0] rawBtns;
    logic [NUM_BTNS-1:0] levels;
    logic [NUM_BTNS-1:0] heldMask;
    logic [NUM_BTNS-1:0] otherLevels;
    logic [2:0]          pressedCount;
    logic [2:0]          activeCode;

    btn_state_e state_q;
    logic       pressValid_q;
    logic [2:0] pressCode_q;
    logic       btnHeld_q;
    logic [2:0] heldCode_q;
    logic       multiPress_q;

    // Bit position equals the button code so the encoder and masks line up.
    assign rawBtns = {BTNC, BTNR, BTNL, BTND, BTNU};

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_debounce
        debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_debounce (
            .clk_i   (CLK),
            .rst_ni  (CPU_RESETN),
            .btn_i   (rawBtns[i]),
            .level_o (levels[i])
        );
    end

    // Code of the pressed button; only consulted when exactly one is high.
    always_comb begin
        activeCode = BTN_U;
        if (levels[BTN_U]) begin
            activeCode = BTN_U;
        end else if (levels[BTN_D]) begin
            activeCode = BTN_D;
        end else if (levels[BTN_L]) begin
            activeCode = BTN_L;
        end else if (levels[BTN_R]) begin
            activeCode = BTN_R;
        end else if (levels[BTN_C]) begin
            activeCode = BTN_C;
        end
    end

    // Isolate the accepted button so any other press can be spotted in HELD.
    always_comb begin
        heldMask = '0;
        case (heldCode_q)
            BTN_U:   heldMask = 5'b00001;
            BTN_D:   heldMask = 5'b00010;
            BTN_L:   heldMask = 5'b00100;
            BTN_R:   heldMask = 5'b01000;
            BTN_C:   heldMask = 5'b10000;
            default: heldMask = '0;
        endcase
    end

    assign otherLevels  = levels & ~heldMask;
    assign pressedCount = countPressed(levels);

    // Press FSM. Outputs are updated on the same edge as the state so they
    // are all registered. From IDLE the buttons all start low, so two or
    // more high at once means they rose together and must be locked out.
    always_ff @(posedge CLK or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q      <= ST_IDLE;
            pressValid_q <= 1'b0;
            pressCode_q  <= BTN_U;
            btnHeld_q    <= 1'b0;
            heldCode_q   <= BTN_U;
            multiPress_q <= 1'b0;
        end else begin
            pressValid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pressedCount == 3'd1) begin
                        state_q      <= ST_HELD;
                        pressValid_q <= 1'b1;
                        pressCode_q  <= activeCode;
                        heldCode_q   <= activeCode;
                        btnHeld_q    <= 1'b1;
                    end else if (pressedCount >= 3'd2) begin
                        state_q      <= ST_LOCKOUT;
                        multiPress_q <= 1'b1;
                    end
                end
                ST_HELD: begin
                    if (otherLevels != '0) begin
                        state_q      <= ST_LOCKOUT;
                        btnHeld_q    <= 1'b0;
                        multiPress_q <= 1'b1;
                    end else if ((levels & heldMask) == '0) begin
                        state_q   <= ST_IDLE;
                        btnHeld_q <= 1'b0;
                    end
                end
                ST_LOCKOUT: begin
                    if (levels == '0) begin
                        state_q      <= ST_IDLE;
                        multiPress_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    btnHeld_q    <= 1'b0;
                    multiPress_q <= 1'b0;
                end
            endcase
        end
    end

    assign press_valid = pressValid_q;
    assign press_code  = pressCode_q;
    assign btn_held    = btnHeld_q;
    assign held_code   = heldCode_q;
    assign multi_press = multiPress_q;

endmodule
